// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment run/pause/clear path.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seg_state_t;

  localparam int unsigned DIV_1HZ = 50_000_000;
  localparam int unsigned BCD_W   = 4;

  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = BCD_W'(v / 10);
    units = BCD_W'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Count-tick divider: one-cycle registered tick every DIV enabled cycles.
module seg_tick_div
  import seg_pkg::*;
#(
  parameter int unsigned DIV = DIV_1HZ
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         r_tick;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (en) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/seg_run_ctrl.sv
// Run/pause/clear controller driving a two-digit BCD count from key pulses.
// Optional SEG_RUN_AUTOSTOP_EN: stop in PAUSE at CNT_MAX and add the done output.
module seg_run_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIV     = DIV_1HZ,
  parameter int unsigned CNT_MAX = 99
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_clear,
  output logic       tick,
  output logic       running,
  output logic       paused,
`ifdef SEG_RUN_AUTOSTOP_EN
  output logic       done,
`endif
  output logic [7:0] cnt_bcd
);

  localparam logic [2*BCD_W-1:0] MAX_BCD = to_bcd(CNT_MAX);
`ifdef SEG_RUN_AUTOSTOP_EN
  localparam logic [2*BCD_W-1:0] PRE_BCD = to_bcd(CNT_MAX - 1);
`endif

  seg_state_t           r_state;
  seg_state_t           w_next;
  logic                 w_tick;
  logic                 r_running;
  logic                 r_paused;
  logic [2*BCD_W-1:0]   r_cnt;
  logic [2*BCD_W-1:0]   w_cnt_inc;
  logic [2*BCD_W-1:0]   w_cnt_next;
  logic [BCD_W-1:0]     w_units;
  logic [BCD_W-1:0]     w_tens;

  seg_tick_div #(
    .DIV (DIV)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .en       (r_state == RUN),
    .clr      (key_clear),
    .tick     (w_tick)
  );

  assign w_units = r_cnt[BCD_W-1:0];
  assign w_tens  = r_cnt[2*BCD_W-1:BCD_W];

  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt == MAX_BCD) begin
`ifdef SEG_RUN_AUTOSTOP_EN
      w_cnt_inc = r_cnt;
`else
      w_cnt_inc = '0;
`endif
    end else if (w_units == BCD_W'(9)) begin
      w_cnt_inc = {w_tens + BCD_W'(1), BCD_W'(0)};
    end else begin
      w_cnt_inc = {w_tens, w_units + BCD_W'(1)};
    end
  end

  // The count advances on the edge that consumes the registered tick.
  always_comb begin
    w_cnt_next = r_cnt;
    if (key_clear) begin
      w_cnt_next = '0;
    end else if (w_tick) begin
      w_cnt_next = w_cnt_inc;
    end
  end

  always_comb begin
    w_next = r_state;
    if (key_clear) begin
      w_next = IDLE;
`ifdef SEG_RUN_AUTOSTOP_EN
    end else if (w_tick && (r_cnt == PRE_BCD)) begin
      w_next = PAUSE;
`endif
    end else if (key_start) begin
      unique case (r_state)
        IDLE:    w_next = RUN;
        RUN:     w_next = PAUSE;
        PAUSE: begin
`ifdef SEG_RUN_AUTOSTOP_EN
          if (r_cnt != MAX_BCD) w_next = RUN;
`else
          w_next = RUN;
`endif
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == RUN);
      r_paused  <= (w_next == PAUSE);
      r_cnt     <= w_cnt_next;
    end
  end

`ifdef SEG_RUN_AUTOSTOP_EN
  logic r_done;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_next == PAUSE) && (w_cnt_next == MAX_BCD);
    end
  end

  assign done = r_done;
`endif

  assign tick    = w_tick;
  assign running = r_running;
  assign paused  = r_paused;
  assign cnt_bcd = r_cnt;

endmodule

// File: tb/tb_seg_run_ctrl.sv
// Bench for seg_run_ctrl: two instances (DIV=4/MAX=99 and DIV=3/MAX=12) share key stimulus.
module tb_seg_run_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
`ifdef SEG_RUN_AUTOSTOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ks  = 1'b0;
  logic       kc  = 1'b0;
  logic       tick0, run0, pau0, tick1, run1, pau1;
  logic [7:0] cnt0, cnt1;
`ifdef SEG_RUN_AUTOSTOP_EN
  logic       done0, done1;
`endif

  always #5 clk = ~clk;

  seg_run_ctrl #(.DIV(4), .CNT_MAX(99)) u0 (
    .CLOCK_50 (clk), .rst (rst), .key_start (ks), .key_clear (kc),
    .tick (tick0), .running (run0), .paused (pau0),
`ifdef SEG_RUN_AUTOSTOP_EN
    .done (done0),
`endif
    .cnt_bcd (cnt0)
  );

  seg_run_ctrl #(.DIV(3), .CNT_MAX(12)) u1 (
    .CLOCK_50 (clk), .rst (rst), .key_start (ks), .key_clear (kc),
    .tick (tick1), .running (run1), .paused (pau1),
`ifdef SEG_RUN_AUTOSTOP_EN
    .done (done1),
`endif
    .cnt_bcd (cnt1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run cycles since clear, tick count as an integer.
  int P_DIV [2] = '{4, 3};
  int P_MAX [2] = '{99, 12};
  int m_st  [2];
  int m_rc  [2];
  int m_n   [2];
  bit m_t   [2];
  int q0[$];
  int q1[$];

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic push(input int i, input int v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_rc[i] = 0; m_n[i] = 0; m_t[i] = 1'b0;
    end
  endtask

  task automatic step(input int i, input bit s, input bit c);
    int st, nn, nrc, ns;
    bit nt, land;
    st = m_st[i]; nn = m_n[i]; nrc = m_rc[i]; ns = st; land = 1'b0;
    if (m_t[i]) begin
      if (m_n[i] >= P_MAX[i]) nn = AUTO ? m_n[i] : 0;
      else                    nn = m_n[i] + 1;
      land = AUTO && (nn == P_MAX[i]) && (m_n[i] != P_MAX[i]);
    end
    if (st == M_RUN) nrc = m_rc[i] + 1;
    nt = (st == M_RUN) && (nrc % P_DIV[i] == 0);
    if (land) ns = M_PAUSE;
    else if (s) begin
      case (st)
        M_IDLE:  ns = M_RUN;
        M_RUN:   ns = M_PAUSE;
        default: if (!(AUTO && m_n[i] == P_MAX[i])) ns = M_RUN;
      endcase
    end
    if (c) begin
      ns = M_IDLE; nn = 0; nrc = 0; nt = 1'b0;
    end
    if (m_t[i]) push(i, bcd(nn));
    m_st[i] = ns; m_n[i] = nn; m_rc[i] = nrc; m_t[i] = nt;
  endtask

  task automatic check_outputs();
    chk("u0.tick",    32'(tick0), 32'(m_t[0]));
    chk("u0.running", 32'(run0),  32'(m_st[0] == M_RUN));
    chk("u0.paused",  32'(pau0),  32'(m_st[0] == M_PAUSE));
    chk("u0.cnt_bcd", 32'(cnt0),  32'(bcd(m_n[0])));
    chk("u1.tick",    32'(tick1), 32'(m_t[1]));
    chk("u1.running", 32'(run1),  32'(m_st[1] == M_RUN));
    chk("u1.paused",  32'(pau1),  32'(m_st[1] == M_PAUSE));
    chk("u1.cnt_bcd", 32'(cnt1),  32'(bcd(m_n[1])));
`ifdef SEG_RUN_AUTOSTOP_EN
    chk("u0.done", 32'(done0), 32'(m_st[0] == M_PAUSE && m_n[0] == P_MAX[0]));
    chk("u1.done", 32'(done1), 32'(m_st[1] == M_PAUSE && m_n[1] == P_MAX[1]));
`endif
  endtask

  // Inputs are applied at a falling edge and sampled by the next rising edge.
  task automatic cycle(input bit s, input bit c);
    ks = s; kc = c;
    step(0, s, c);
    step(1, s, c);
    @(negedge clk);
    ks = 1'b0; kc = 1'b0;
    check_outputs();
  endtask

  task automatic reset_mid();
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) if (m_t[i]) push(i, 0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // Scoreboard monitors: each observed tick is followed by the expected count.
  logic [7:0] e0, e1;
  bit pend0 = 1'b0;
  bit pend1 = 1'b0;

  initial forever begin
    @(negedge clk);
    if (pend0) begin
      if (q0.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL sb0_unexpected_tick: actual=%0h required=no tick", cnt0);
      end else begin
        e0 = 8'(q0.pop_front());
        chk("sb0_cnt", 32'(cnt0), 32'(e0));
      end
    end
    pend0 = tick0;
  end

  initial forever begin
    @(negedge clk);
    if (pend1) begin
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL sb1_unexpected_tick: actual=%0h required=no tick", cnt1);
      end else begin
        e1 = 8'(q1.pop_front());
        chk("sb1_cnt", 32'(cnt1), 32'(e1));
      end
    end
    pend1 = tick1;
  end

  initial begin
    int n;
    int t;
    int k;
    int tpos [3];
    bit want_post;
    bit s, c;

    model_reset();
    @(negedge clk);
    check_outputs();
    chk("reset_cnt", 32'(cnt0), 32'h00);
    chk("reset_running", 32'(run0), 32'h0);
    rst = 1'b0;

    n = 0;
    for (int j = 0; j < 100; j++) begin
      cycle(1'b0, 1'b0);
      if (tick0 || tick1) n++;
    end
    chk("idle_no_tick", 32'(n), 32'd0);
    chk("idle_cnt", 32'(cnt0), 32'h00);

    cycle(1'b1, 1'b0);
    chk("start_running", 32'(run0), 32'h1);
    n = 0;
    for (int j = 1; j <= 13; j++) begin
      cycle(1'b0, 1'b0);
      if (tick0 && n < 3) begin
        tpos[n] = j;
        n++;
      end
    end
    chk("tick_count_13", 32'(n), 32'd3);
    chk("tick1_pos", 32'(tpos[0]), 32'd4);
    chk("tick2_pos", 32'(tpos[1]), 32'd8);
    chk("tick3_pos", 32'(tpos[2]), 32'd12);
    chk("cnt_after_3", 32'(cnt0), 32'h03);

    t = 3; k = 0; want_post = 1'b0;
    while (t < 41 && k < 1000) begin
      cycle(1'b0, 1'b0);
      k++;
      if (want_post) begin
        chk("carry_post", 32'(cnt0), 32'h10);
        want_post = 1'b0;
      end
      if (tick0) begin
        t++;
        if (t == 10) begin
          chk("carry_pre", 32'(cnt0), 32'h09);
          want_post = 1'b1;
        end
      end
    end
    chk("ticks_41_reached", 32'(t), 32'd41);
    cycle(1'b0, 1'b0);
    chk("cnt_41", 32'(cnt0), 32'h41);

    cycle(1'b1, 1'b0);
    chk("pause_paused", 32'(pau0), 32'h1);
    n = 0;
    for (int j = 0; j < 20; j++) begin
      cycle(1'b0, 1'b0);
      if (tick0) n++;
    end
    chk("pause_no_tick", 32'(n), 32'd0);
    chk("pause_cnt_hold", 32'(cnt0), 32'h41);
    cycle(1'b1, 1'b0);
    chk("resume_running", 32'(run0), 32'h1);
    cycle(1'b0, 1'b0);
    chk("resume_tick_early", 32'(tick0), 32'h0);
    cycle(1'b0, 1'b0);
    chk("resume_tick", 32'(tick0), 32'h1);

    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    k = 0;
    while (cnt0 != 8'h07 && k < 200) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    chk("reach_07", 32'(cnt0), 32'h07);
    cycle(1'b1, 1'b1);
    chk("both_keys_running", 32'(run0), 32'h0);
    chk("both_keys_paused", 32'(pau0), 32'h0);
    chk("both_keys_cnt", 32'(cnt0), 32'h00);

    cycle(1'b1, 1'b0);
    k = 0;
    while (cnt1 != 8'h12 && k < 200) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    chk("u1_reach_12", 32'(cnt1), 32'h12);
`ifdef SEG_RUN_AUTOSTOP_EN
    chk("auto_paused", 32'(pau1), 32'h1);
    chk("auto_done", 32'(done1), 32'h1);
    cycle(1'b1, 1'b0);
    for (int j = 0; j < 5; j++) cycle(1'b0, 1'b0);
    chk("auto_start_ignored", 32'(pau1), 32'h1);
    chk("auto_cnt_held", 32'(cnt1), 32'h12);
    cycle(1'b0, 1'b1);
    chk("auto_clear_cnt", 32'(cnt1), 32'h00);
    chk("auto_clear_done", 32'(done1), 32'h0);
`else
    k = 0;
    while (!tick1 && k < 20) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    chk("u1_tick_at_12", 32'(tick1), 32'h1);
    cycle(1'b0, 1'b0);
    chk("wrap_to_00", 32'(cnt1), 32'h00);
`endif

    cycle(1'b0, 1'b1);
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 799) == 0) begin
        reset_mid();
      end else begin
        s = ($urandom_range(0, 24) == 0);
        c = ($urandom_range(0, 199) == 0);
        cycle(s, c);
      end
    end

    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
